// File: rtl/lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the funct3 encodings, the controller state constants and the small
// helpers used to classify and size an access.
package lsu_pkg;

    // funct3 encodings of the supported loads/stores
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Controller states
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ1 = 2'd1;
    localparam logic [1:0] REQ2 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == LSU_B) || (f3 == LSU_H) || (f3 == LSU_W) ||
               (f3 == LSU_BU) || (f3 == LSU_HU);
    endfunction

    // Byte-enable pattern for an access at byte offset 0
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the load/store unit.
// Ports:
//   off, funct3      byte offset and access type of the current access
//   st_data          right-justified store data
//   be_cur, rdata    byte enables of the transaction being acked and its read data
//   ld_buf           bytes captured from an earlier transaction of the same load
//   wdata            store data rotated into byte lanes (both transactions use it)
//   be_lo, be_hi     byte enables of the first and second word
//   merged           ld_buf with the lanes of the current transaction replaced
//   ld_ext           merged word shifted down and sign/zero extended
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [31:0] st_data,
    input  logic [3:0]  be_cur,
    input  logic [31:0] rdata,
    input  logic [31:0] ld_buf,
    output logic [31:0] wdata,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] merged,
    output logic [31:0] ld_ext
);

    logic [7:0]  be_wide;
    logic [5:0]  sh;
    logic [31:0] ld_rot;

    // Enables that spill past lane 3 belong to the following word.
    assign be_wide = {4'b0000, size_mask(funct3)} << off;
    assign be_lo   = be_wide[3:0];
    assign be_hi   = be_wide[7:4];

    // Rotation puts the spilled bytes in the low lanes, so the second word
    // reuses the same data with be_hi.
    assign sh    = {1'b0, off, 3'b000};
    assign wdata = (st_data << sh) | (st_data >> (6'd32 - sh));

    always_comb begin
        merged = ld_buf;
        for (int i = 0; i < 4; i++) begin
            if (be_cur[i]) begin
                merged[8*i +: 8] = rdata[8*i +: 8];
            end
        end
    end

    assign ld_rot = (merged >> sh) | (merged << (6'd32 - sh));

    always_comb begin
        case (funct3)
            LSU_B:   ld_ext = {{24{ld_rot[7]}}, ld_rot[7:0]};
            LSU_H:   ld_ext = {{16{ld_rot[15]}}, ld_rot[15:0]};
            LSU_BU:  ld_ext = {24'd0, ld_rot[7:0]};
            LSU_HU:  ld_ext = {16'd0, ld_rot[15:0]};
            default: ld_ext = ld_rot;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller.
// Turns each load/store from the EX/MEM register into one or two word-aligned
// req/ack bus transactions, assembles load data for MEM/WB and stalls the
// upstream pipeline while the access is in flight.
// Ports:
//   i_clk, i_reset            clock, asynchronous active-low reset
//   inst_vld_mem, mem_wren_mem, lsu_op_mem, alu_data_mem, rs2_data_mem
//                             instruction in MEM: valid, store flag, op, address, store data
//   o_stall_mem               hold EX/MEM and earlier stages
//   o_ld_data_mem, o_ld_vld_mem  extended load result and its one-cycle valid
//   o_bus_req/we/addr/be/wdata   registered bus request, held until acked
//   i_bus_ack, i_bus_rdata    transaction completion and read data
//   o_bus_err                 one-cycle pulse when a transaction times out
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              inst_vld_mem,
    input  logic              mem_wren_mem,
    input  logic [3:0]        lsu_op_mem,
    input  logic [ADDR_W-1:0] alu_data_mem,
    input  logic [31:0]       rs2_data_mem,
    output logic              o_stall_mem,
    output logic [31:0]       o_ld_data_mem,
    output logic              o_ld_vld_mem,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [31:0]       i_bus_rdata,
    output logic              o_bus_err
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       off_q;
    logic [2:0]       f3_q;
    logic [3:0]       be_hi_q;
    logic [31:0]      ld_buf;
    logic [CNT_W-1:0] cnt;

    logic        start;
    logic        in_req;
    logic        ack_ok;
    logic [1:0]  off_sel;
    logic [2:0]  f3_sel;
    logic [31:0] wdata_rot;
    logic [31:0] merged;
    logic [31:0] ld_ext;
    logic [3:0]  be_lo;
    logic [3:0]  be_hi;

    assign start  = inst_vld_mem & lsu_op_mem[3] & f3_legal(lsu_op_mem[2:0]) & (state == IDLE);
    assign in_req = (state == REQ1) | (state == REQ2);
    // Gated by reset so a held instruction cannot stall the pipe during reset.
    assign o_stall_mem = i_reset & (start | in_req);
    assign ack_ok      = i_bus_ack & o_bus_req;

    // In IDLE the aligner works on the live inputs to build the first request;
    // afterwards it works on the latched access for load assembly.
    assign off_sel = (state == IDLE) ? alu_data_mem[1:0] : off_q;
    assign f3_sel  = (state == IDLE) ? lsu_op_mem[2:0] : f3_q;

    lsu_align u_align (
        .off     (off_sel),
        .funct3  (f3_sel),
        .st_data (rs2_data_mem),
        .be_cur  (o_bus_be),
        .rdata   (i_bus_rdata),
        .ld_buf  (ld_buf),
        .wdata   (wdata_rot),
        .be_lo   (be_lo),
        .be_hi   (be_hi),
        .merged  (merged),
        .ld_ext  (ld_ext)
    );

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            off_q         <= '0;
            f3_q          <= '0;
            be_hi_q       <= '0;
            ld_buf        <= '0;
            cnt           <= '0;
            o_bus_req     <= 1'b0;
            o_bus_we      <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_be      <= '0;
            o_bus_wdata   <= '0;
            o_ld_data_mem <= '0;
            o_ld_vld_mem  <= 1'b0;
            o_bus_err     <= 1'b0;
        end else begin
            o_ld_vld_mem <= 1'b0;
            o_bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= REQ1;
                        off_q       <= alu_data_mem[1:0];
                        f3_q        <= lsu_op_mem[2:0];
                        be_hi_q     <= be_hi;
                        ld_buf      <= '0;
                        cnt         <= '0;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= mem_wren_mem;
                        o_bus_addr  <= {alu_data_mem[ADDR_W-1:2], 2'b00};
                        o_bus_be    <= be_lo;
                        o_bus_wdata <= wdata_rot;
                    end
                end
                REQ1, REQ2: begin
                    if (ack_ok) begin
                        ld_buf <= merged;
                        if ((state == REQ1) && (be_hi_q != 4'b0000)) begin
                            // Second word wraps naturally at the top of memory.
                            state      <= REQ2;
                            cnt        <= '0;
                            o_bus_addr <= o_bus_addr + ADDR_W'(4);
                            o_bus_be   <= be_hi_q;
                        end else begin
                            state     <= DONE;
                            o_bus_req <= 1'b0;
                            o_bus_we  <= 1'b0;
                            if (!o_bus_we) begin
                                o_ld_vld_mem  <= 1'b1;
                                o_ld_data_mem <= ld_ext;
                            end
                        end
                    end else if (cnt == CNT_LAST) begin
                        state         <= DONE;
                        o_bus_req     <= 1'b0;
                        o_bus_we      <= 1'b0;
                        o_bus_err     <= 1'b1;
                        o_ld_data_mem <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    localparam int ACK_TIMEOUT = 255;

    logic        clk;
    logic        rst_n;
    logic        inst_vld_mem;
    logic        mem_wren_mem;
    logic [3:0]  lsu_op_mem;
    logic [31:0] alu_data_mem;
    logic [31:0] rs2_data_mem;
    logic        o_stall_mem;
    logic [31:0] o_ld_data_mem;
    logic        o_ld_vld_mem;
    logic        o_bus_req;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [3:0]  o_bus_be;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;
    logic        o_bus_err;

    lsu_mem_ctrl #(.ADDR_W(32), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .inst_vld_mem  (inst_vld_mem),
        .mem_wren_mem  (mem_wren_mem),
        .lsu_op_mem    (lsu_op_mem),
        .alu_data_mem  (alu_data_mem),
        .rs2_data_mem  (rs2_data_mem),
        .o_stall_mem   (o_stall_mem),
        .o_ld_data_mem (o_ld_data_mem),
        .o_ld_vld_mem  (o_ld_vld_mem),
        .o_bus_req     (o_bus_req),
        .o_bus_we      (o_bus_we),
        .o_bus_addr    (o_bus_addr),
        .o_bus_be      (o_bus_be),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_ack     (i_bus_ack),
        .i_bus_rdata   (i_bus_rdata),
        .o_bus_err     (o_bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Bus-side memory (word granular) and reference memory (byte granular).
    logic [31:0] bus_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    // Results of the latest access
    int          r_ntx;
    int          r_stall;
    int          r_vld;
    logic        r_err;
    logic [31:0] r_ld;
    logic        stable_bad;
    logic [31:0] tx_addr [2];
    logic [3:0]  tx_be   [2];
    logic [31:0] tx_wd   [2];

    logic [2:0] ld_ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] st_ops [3] = '{3'b000, 3'b001, 3'b010};

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [31:0] exp_ld;
        int          ntx;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] b);
        logic [31:0] w;
        if (ref_mem.exists(b)) return ref_mem[b];
        w = init_word({b[31:2], 2'b00});
        return w[8*b[1:0] +: 8];
    endfunction

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Little-endian gather of the addressed bytes, then extend per funct3.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < acc_size(f3); i++) v[8*i +: 8] = ref_byte(a + 32'(i));
        case (f3)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            default: return v;
        endcase
    endfunction

    // Presents one access, plays the bus slave (ack after dly wait cycles,
    // never when dly < 0) and records what the DUT did until it completes.
    task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] d, input int dly);
        int          cycles;
        int          wcnt;
        logic        started;
        logic        done;
        logic        first;
        logic [68:0] snap;
        logic [31:0] w;
        inst_vld_mem = 1'b1;
        mem_wren_mem = we;
        lsu_op_mem   = {1'b1, f3};
        alu_data_mem = a;
        rs2_data_mem = d;
        r_ntx = 0; r_stall = 0; r_vld = 0; r_err = 1'b0; r_ld = '0; stable_bad = 1'b0;
        started = 1'b0; done = 1'b0; first = 1'b1; cycles = 0; wcnt = 0; snap = '0;
        while (!done && cycles < 600) begin
            @(negedge clk);
            cycles++;
            i_bus_ack   = 1'b0;
            i_bus_rdata = $urandom;
            if (o_stall_mem) begin
                r_stall++;
                started = 1'b1;
            end
            if (o_bus_err) r_err = 1'b1;
            if (o_ld_vld_mem) begin
                r_vld++;
                r_ld = o_ld_data_mem;
            end
            if (o_bus_req) begin
                if (first) begin
                    snap  = {o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata};
                    first = 1'b0;
                end else if ({o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata} != snap) begin
                    stable_bad = 1'b1;
                end
                if (dly >= 0 && wcnt >= dly) begin
                    if (r_ntx < 2) begin
                        tx_addr[r_ntx] = o_bus_addr;
                        tx_be[r_ntx]   = o_bus_be;
                        tx_wd[r_ntx]   = o_bus_wdata;
                    end
                    r_ntx++;
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = bus_rd(o_bus_addr);
                    if (o_bus_we) begin
                        w = bus_rd(o_bus_addr);
                        for (int i = 0; i < 4; i++)
                            if (o_bus_be[i]) w[8*i +: 8] = o_bus_wdata[8*i +: 8];
                        bus_mem[o_bus_addr] = w;
                    end
                    wcnt  = 0;
                    first = 1'b1;
                end else begin
                    wcnt++;
                end
            end
            if (started && !o_stall_mem) done = 1'b1;
            @(posedge clk);
            #1;
        end
        i_bus_ack    = 1'b0;
        inst_vld_mem = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL access_bound actual=incomplete required=complete addr=%h", a);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        inst_vld_mem = 1'b1;
        mem_wren_mem = 1'b0;
        lsu_op_mem = 4'b1010;
        alu_data_mem = 32'h1000;
        rs2_data_mem = '0;
        i_bus_ack = 1'b0;
        i_bus_rdata = '0;

        vecs[0] = '{1'b0, 3'b010, 32'h00001000, 32'h0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF,
                    1, 32'h00001000, 4'b1111, 32'h0, 32'h0, 4'b0000, 32'h0};
        vecs[1] = '{1'b0, 3'b000, 32'h00001003, 32'h0, 32'h80FF0000, 32'h0, 32'hFFFFFF80,
                    1, 32'h00001000, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0};
        vecs[2] = '{1'b0, 3'b100, 32'h00001003, 32'h0, 32'h80FF0000, 32'h0, 32'h00000080,
                    1, 32'h00001000, 4'b1000, 32'h0, 32'h0, 4'b0000, 32'h0};
        vecs[3] = '{1'b1, 3'b010, 32'h00001002, 32'h11223344, 32'h0, 32'h0, 32'h0,
                    2, 32'h00001000, 4'b1100, 32'h33440000, 32'h00001004, 4'b0011, 32'h00001122};
        vecs[4] = '{1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 32'hAB000000, 32'h000000CD, 32'hFFFFCDAB,
                    2, 32'hFFFFFFFC, 4'b1000, 32'h0, 32'h00000000, 4'b0001, 32'h0};
        vecs[5] = '{1'b0, 3'b101, 32'h00001002, 32'h0, 32'h80010000, 32'h0, 32'h00008001,
                    1, 32'h00001000, 4'b1100, 32'h0, 32'h0, 4'b0000, 32'h0};
        vecs[6] = '{1'b0, 3'b010, 32'h00001003, 32'h0, 32'h44000000, 32'h00332211, 32'h33221144,
                    2, 32'h00001000, 4'b1000, 32'h0, 32'h00001004, 4'b0111, 32'h0};
        vecs[7] = '{1'b1, 3'b000, 32'h00001001, 32'h000000A5, 32'h0, 32'h0, 32'h0,
                    1, 32'h00001000, 4'b0010, 32'h0000A500, 32'h0, 4'b0000, 32'h0};
        vecs[8] = '{1'b1, 3'b001, 32'h00001003, 32'h0000BEEF, 32'h0, 32'h0, 32'h0,
                    2, 32'h00001000, 4'b1000, 32'hEF000000, 32'h00001004, 4'b0001, 32'h000000BE};

        // Reset state, with a legal access held at the inputs
        #3;
        chk("rst_stall", {31'd0, o_stall_mem}, 32'd0);
        chk("rst_req", {31'd0, o_bus_req}, 32'd0);
        chk("rst_we", {31'd0, o_bus_we}, 32'd0);
        chk("rst_addr", o_bus_addr, 32'd0);
        chk("rst_be", {28'd0, o_bus_be}, 32'd0);
        chk("rst_wdata", o_bus_wdata, 32'd0);
        chk("rst_ld_data", o_ld_data_mem, 32'd0);
        chk("rst_ld_vld", {31'd0, o_ld_vld_mem}, 32'd0);
        chk("rst_err", {31'd0, o_bus_err}, 32'd0);
        inst_vld_mem = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int v = 0; v < 9; v++) begin
            bus_mem[vecs[v].a0] = vecs[v].rd0;
            if (vecs[v].ntx == 2) bus_mem[vecs[v].a1] = vecs[v].rd1;
            run_access(vecs[v].we, vecs[v].f3, vecs[v].addr, vecs[v].data, 0);
            chk($sformatf("v%0d_ntx", v), 32'(r_ntx), 32'(vecs[v].ntx));
            chk($sformatf("v%0d_stall", v), 32'(r_stall), 32'(vecs[v].ntx + 1));
            chk($sformatf("v%0d_a0", v), tx_addr[0], vecs[v].a0);
            chk($sformatf("v%0d_be0", v), {28'd0, tx_be[0]}, {28'd0, vecs[v].be0});
            chk($sformatf("v%0d_ld_vld", v), 32'(r_vld), vecs[v].we ? 32'd0 : 32'd1);
            if (!vecs[v].we) chk($sformatf("v%0d_ld", v), r_ld, vecs[v].exp_ld);
            else chk($sformatf("v%0d_wd0", v), tx_wd[0] & lanes(vecs[v].be0), vecs[v].wd0);
            if (vecs[v].ntx == 2 && r_ntx == 2) begin
                chk($sformatf("v%0d_a1", v), tx_addr[1], vecs[v].a1);
                chk($sformatf("v%0d_be1", v), {28'd0, tx_be[1]}, {28'd0, vecs[v].be1});
                if (vecs[v].we)
                    chk($sformatf("v%0d_wd1", v), tx_wd[1] & lanes(vecs[v].be1), vecs[v].wd1);
            end
        end

        // Ack delayed by 5 cycles: request held stable, stall held
        bus_mem[32'h5000] = 32'h0BADF00D;
        run_access(1'b0, 3'b010, 32'h5000, 32'h0, 5);
        chk("dly_stable", {31'd0, stable_bad}, 32'd0);
        chk("dly_stall", 32'(r_stall), 32'd7);
        chk("dly_ntx", 32'(r_ntx), 32'd1);
        chk("dly_ld", r_ld, 32'h0BADF00D);

        // No ack at all: timeout abort
        run_access(1'b0, 3'b010, 32'h7000, 32'h0, -1);
        chk("to_err", {31'd0, r_err}, 32'd1);
        chk("to_stall", 32'(r_stall), 32'(ACK_TIMEOUT + 1));
        chk("to_ld_data", o_ld_data_mem, 32'd0);
        chk("to_ntx", 32'(r_ntx), 32'd0);

        // Illegal funct3 and non-memory ops with spurious acks: nothing happens
        inst_vld_mem = 1'b1;
        mem_wren_mem = 1'b0;
        alu_data_mem = 32'h1000;
        for (int c = 0; c < 6; c++) begin
            lsu_op_mem = (c < 4) ? 4'b1011 : 4'b0010;
            @(negedge clk);
            chk($sformatf("ill%0d_req", c), {31'd0, o_bus_req}, 32'd0);
            chk($sformatf("ill%0d_stall", c), {31'd0, o_stall_mem}, 32'd0);
            chk($sformatf("ill%0d_ld_vld", c), {31'd0, o_ld_vld_mem}, 32'd0);
            i_bus_ack = 1'b1;
            @(posedge clk);
            #1;
            i_bus_ack = 1'b0;
        end
        inst_vld_mem = 1'b0;

        // Reset pulse while the second word of a split load is outstanding
        inst_vld_mem = 1'b1;
        mem_wren_mem = 1'b0;
        lsu_op_mem   = 4'b1010;
        alu_data_mem = 32'h6001;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        i_bus_ack   = 1'b1;
        i_bus_rdata = 32'h12345678;
        @(posedge clk);
        #1;
        i_bus_ack = 1'b0;
        @(negedge clk);
        chk("mid_req2_addr", o_bus_addr, 32'h6004);
        chk("mid_req2_req", {31'd0, o_bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, o_bus_req}, 32'd0);
        chk("mid_rst_stall", {31'd0, o_stall_mem}, 32'd0);
        inst_vld_mem = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_req", c), {31'd0, o_bus_req}, 32'd0);
            chk($sformatf("post_rst%0d_vld", c), {31'd0, o_ld_vld_mem}, 32'd0);
        end
        @(posedge clk);
        #1;

        // Randomized accesses against the byte-level reference memory
        bus_mem.delete();
        ref_mem.delete();
        for (int k = 0; k < 200; k++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] exp;
            int          dly;
            int          n;
            int          extx;
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            a  = ($urandom_range(0, 1) == 1) ? 32'h4000 + 32'($urandom_range(0, 31))
                                             : 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            d   = $urandom;
            dly = int'($urandom_range(0, 3));
            n   = acc_size(f3);
            extx = (int'(a[1:0]) + n > 4) ? 2 : 1;
            exp = we ? 32'h0 : ref_load(f3, a);
            run_access(we, f3, a, d, dly);
            if (we) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = d[8*i +: 8];
            chk("rnd_ntx", 32'(r_ntx), 32'(extx));
            chk("rnd_stall", 32'(r_stall), 32'(1 + extx * (dly + 1)));
            chk("rnd_a0", tx_addr[0], {a[31:2], 2'b00});
            if (extx == 2 && r_ntx == 2) chk("rnd_a1", tx_addr[1], {a[31:2], 2'b00} + 32'd4);
            chk("rnd_stable", {31'd0, stable_bad}, 32'd0);
            chk("rnd_ld_vld", 32'(r_vld), we ? 32'd0 : 32'd1);
            if (!we) chk("rnd_ld", r_ld, exp);
        end

        begin
            int bad;
            logic [31:0] w;
            bad = 0;
            foreach (ref_mem[b]) begin
                w = bus_rd({b[31:2], 2'b00});
                if (w[8*b[1:0] +: 8] !== ref_mem[b]) bad++;
            end
            chk("mem_image_bad_bytes", 32'(bad), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
MEM-stage load/store controller fed directly by the EX/MEM pipeline register outputs (alu_data_mem, rs2_data_mem, mem_wren_mem, lsu_op_mem, inst_vld_mem).
- Converts each load/store into one or two word-aligned transactions on a req/ack data bus.
- Splits misaligned halfword/word accesses across two words.
- Merges, shifts and sign-extends load data for MEM/WB.
- Raises a stall that freezes the upstream pipeline (EX/MEM enable low) until the access completes.

Parameters:
ADDR_W, 32, byte-address width of alu_data_mem and o_bus_addr.
ACK_TIMEOUT, 255, cycles REQ1/REQ2 may wait for i_bus_ack before aborting with o_bus_err.

Ports:
i_clk  in  1  single clock; all state on rising edge.
i_reset  in  1  asynchronous, active-low reset.
inst_vld_mem  in  1  instruction in MEM is valid.
mem_wren_mem  in  1  1 = store, 0 = load.
lsu_op_mem  in  4  [3] = memory access, [2:0] = funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
alu_data_mem  in  32  effective byte address.
rs2_data_mem  in  32  store data, right-justified.
o_stall_mem  out  1  hold EX/MEM and all earlier stages.
o_ld_data_mem  out  32  extended load result.
o_ld_vld_mem  out  1  one-cycle pulse: o_ld_data_mem valid.
o_bus_req  out  1  transaction request.
o_bus_we  out  1  write transaction.
o_bus_addr  out  32  word-aligned address ([1:0]=00).
o_bus_be  out  4  byte enables.
o_bus_wdata  out  32  lane-aligned write data.
i_bus_ack  in  1  transaction complete this cycle.
i_bus_rdata  in  32  read data, valid with i_bus_ack.
o_bus_err  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset values: state IDLE. o_bus_req, o_bus_we, o_ld_vld_mem, o_bus_err = 0. o_bus_addr, o_bus_be, o_bus_wdata, o_ld_data_mem, internal latches, timeout counter = 0. o_stall_mem = 0 while i_reset low.
- Access detect (start) = inst_vld_mem & lsu_op_mem[3] & funct3 legal & state==IDLE. Illegal funct3 (011, 110, 111) = no access; no stall.
- Stall: o_stall_mem = start | state in {REQ1, REQ2}. Low in DONE so EX/MEM advances on the DONE edge. Combinational from inputs.
- IDLE: on start, latch addr/data/op/we; compute be0/be1 and split; go REQ1.
- Split condition: H with addr[1:0]=11; W with addr[1:0]!=00.
- REQ1: o_bus_req=1; addr = A & ~3; be/wdata = lane-shifted low part. On ack, capture rdata bytes, then go REQ2 if split, else DONE.
- REQ2: addr = (A & ~3) + 4, wrapping mod 2^32; remaining bytes in low lanes. On ack go DONE.
- req/addr/be/we/wdata are registered and held stable until the ack cycle. req drops the cycle after ack. Ack while req=0 is ignored.
- DONE: for loads, o_ld_vld_mem=1 and o_ld_data_mem = assembled value (B/H sign-extended, BU/HU zero-extended), held until the next load completes. For stores, no ld_vld. Always return to IDLE; no new start evaluated in DONE.
- Latency: aligned access = 3 cycles with 2 stall cycles when ack arrives in the first REQ cycle; split access = 4 cycles.
- Timeout: counter resets on entering REQ1/REQ2. Reaching ACK_TIMEOUT with no ack → o_bus_err pulse, o_ld_data_mem=0, state DONE.
- Reset asserted mid-transaction: immediate IDLE, req dropped. The in-flight access is abandoned, not replayed.
- Lane shift: byte offset = A[1:0]. Store bytes rotate left by 8*offset; be = size mask << offset. Bits beyond lane 3 go to REQ2 lanes 0.. .

Decomposition:
- Shared package lsu_pkg: funct3 localparams (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU), state enum {IDLE, REQ1, REQ2, DONE}, size-mask function.
- Sub-module lsu_align (combinational): byte-offset rotate/byte-enable generation for stores and merge/extend for loads. FSM and bus registers stay in lsu_mem_ctrl.

Test Plan:
- LW addr 0x0000_1000, rdata 0xDEAD_BEEF, ack on first REQ cycle → one req, be=1111, stall 2 cycles, ld_data 0xDEAD_BEEF with ld_vld pulse.
- LB addr 0x1003, rdata 0x80FF_0000 → be=1000, ld_data 0xFFFF_FF80. LBU same → 0x0000_0080.
- SW addr 0x1002, rs2 0x1122_3344 → req1 addr 0x1000 be=1100 wdata[31:16]=0x3344; req2 addr 0x1004 be=0011 wdata[15:0]=0x1122; stall 3 cycles.
- LH addr 0xFFFF_FFFF, rdata1 0xAB00_0000, rdata2 0x0000_00CD → req2 addr 0x0000_0000; ld_data 0xFFFF_CDAB.
- Ack delayed 5 cycles → request fields stable throughout, stall held; reset pulse during REQ2 → IDLE, req=0, stall=0 immediately.
- No ack for ACK_TIMEOUT cycles → o_bus_err pulse, ld_data 0; funct3=011 with lsu_op[3]=1 → no req, no stall.
